// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the dmem responder slice.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  localparam logic [3:0]  BE_WORD       = 4'b1111;
  localparam logic [3:0]  BE_NONE       = 4'b0000;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;

  // Below-base is tested before the subtraction, so a wrapped offset never aliases into range.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/rv_dmem_resp_if.sv
// Core-side dmem bus: one outstanding word request, single-cycle ready response.
interface rv_dmem_resp_if #(
  parameter int DPWIDTH = 32
);
  logic               dmem_req;
  logic               dmem_we;
  logic [DPWIDTH-1:0] dmem_addr;
  logic [3:0]         dmem_be;
  logic [DPWIDTH-1:0] dmem_wdata;
  logic [DPWIDTH-1:0] dmem_rdata;
  logic               dmem_ready;
  logic               dmem_err;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready, dmem_err
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready, dmem_err
  );
endinterface

// File: rtl/rv_mem_array.sv
// Single-port word RAM with byte write enables and registered read; storage is not reset.
module rv_mem_array #(
  parameter  int DEPTH_WORDS = 1024,
  parameter  int DPWIDTH     = 32,
  localparam int AW          = $clog2(DEPTH_WORDS),
  localparam int NB          = DPWIDTH / 8
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [NB-1:0]      be,
  input  logic [DPWIDTH-1:0] wdata,
  output logic [DPWIDTH-1:0] rdata
);
  logic [DPWIDTH-1:0] mem [DEPTH_WORDS];
  logic [DPWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/rv_dmem_resp.sv
// Data-memory responder: latches one request, waits WAIT_STATES cycles,
// accesses the local RAM and answers with a one-cycle ready pulse.
module rv_dmem_resp
  import rv_mem_pkg::*;
#(
  parameter int          DPWIDTH     = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  rv_dmem_resp_if.slave dmem,
  output logic          busy
);
  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  dmem_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DPWIDTH-1:0] addr_q, addr_d;
  logic [DPWIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               we_q, we_d;
  logic               fault_q, fault_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [DPWIDTH-1:0] rdata_q, rdata_d;

  logic               ram_en;
  logic [AW-1:0]      ram_idx;
  logic [DPWIDTH-1:0] ram_rdata;
  logic               load_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dmem.dmem_req) state_d = (WS == 4'd0) ? ACCESS : WAIT;
      WAIT:    if (cnt_q == WS) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM read lands in RESP, so a good load bypasses the hold register for that cycle.
  assign load_hit = (state_q == RESP) && !we_q && !fault_q;

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    fault_d = fault_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = load_hit ? ram_rdata : rdata_q;
    case (state_q)
      IDLE: begin
        if (dmem.dmem_req) begin
          addr_d  = dmem.dmem_addr;
          wdata_d = dmem.dmem_wdata;
          be_d    = dmem.dmem_be;
          we_d    = dmem.dmem_we;
          fault_d = addr_fault(dmem.dmem_addr, BASE_ADDR, 32'(DEPTH_WORDS));
          cnt_d   = 4'd1;
        end
      end
      WAIT:   cnt_d = cnt_q + 4'd1;
      ACCESS: begin
        ready_d = 1'b1;
        err_d   = fault_q;
      end
      default: ;
    endcase
  end

  assign ram_en  = (state_q == ACCESS) && !fault_q;
  assign ram_idx = AW'((addr_q - BASE_ADDR) >> 2);

  rv_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DPWIDTH     (DPWIDTH)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_q),
    .addr  (ram_idx),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign dmem.dmem_ready = ready_q;
  assign dmem.dmem_err   = err_q;
  assign dmem.dmem_rdata = load_hit ? ram_rdata : rdata_q;
  assign busy            = (state_q != IDLE);
endmodule

// File: doc/rv_dmem_resp.md
Name: rv_dmem_resp

Overview:
- Data-memory responder for the multicycle RISC-V core: the slave end of the core's dmem interface.
- Accepts one word load/store request at a time and holds a local word-addressed RAM.
- Inserts a programmable number of wait states, then returns data or write completion with a one-cycle ready pulse.
- Flags misaligned and out-of-range accesses.

Parameters:
DPWIDTH, 32, data/address width in bits (fixed at 32; byte enables are 4 bits)
DEPTH_WORDS, 1024, number of 32-bit words in the local RAM
BASE_ADDR, 32'h0000_1000, byte address of word 0
WAIT_STATES, 1, extra cycles between request acceptance and response (0..15)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
dmem_req  input  1  request valid; requester holds it and all request fields stable until dmem_ready
dmem_we  input  1  1 = store, 0 = load
dmem_addr  input  DPWIDTH  byte address
dmem_be  input  4  byte enables for stores; ignored for loads
dmem_wdata  input  DPWIDTH  store data
dmem_rdata  output  DPWIDTH  load data, valid when dmem_ready=1 and dmem_we was 0
dmem_ready  output  1  one-cycle response pulse
dmem_err  output  1  qualifies dmem_ready: access faulted
busy  output  1  high from acceptance until the response cycle inclusive

Behaviour:
- Reset (async): FSM to IDLE; dmem_ready=0, dmem_err=0, dmem_rdata=0, busy=0; wait counter=0; request latches cleared. RAM contents are not reset.
- FSM states:
  - IDLE -> WAIT on dmem_req=1, or IDLE -> ACCESS if WAIT_STATES=0.
  - WAIT -> ACCESS when the counter reaches WAIT_STATES.
  - ACCESS -> RESP.
  - RESP -> IDLE.
- Acceptance (IDLE, dmem_req=1):
  - Latch addr, we, be, wdata.
  - Compute fault = (addr[1:0]!=0) or (addr<BASE_ADDR) or (((addr-BASE_ADDR)>>2)>=DEPTH_WORDS).
  - Counter loads 1.
- WAIT: counter increments each cycle; leave when counter==WAIT_STATES.
- ACCESS:
  - No fault, store: bytes with be[i]=1 written to word index (addr-BASE_ADDR)>>2. be=4'b0000 is a legal no-op.
  - No fault, load: word read into dmem_rdata.
  - Fault: no RAM write; dmem_rdata not updated.
- RESP:
  - dmem_ready=1 for exactly one cycle; dmem_err=fault.
  - Outputs are registered.
  - Latency: request accepted at edge N gives dmem_ready high in cycle N+2+WAIT_STATES.
- dmem_rdata holds its last load value outside RESP. dmem_err is 0 whenever dmem_ready=0.
- dmem_req is sampled only in IDLE:
  - A request still high during RESP is not accepted.
  - The earliest back-to-back acceptance is the edge after RESP (IDLE cycle).
- Changes to request fields while busy are ignored; the latched copy is used.
- Reset mid-operation (any state): transaction dropped; a pending store is not written; no ready is produced.
- Load after store to the same word returns the merged data (byte-enable masked).
- Address arithmetic is unsigned DPWIDTH-bit. An addr below BASE_ADDR is a fault before subtraction; no wrap-around.

Decomposition:
- Package rv_mem_pkg:
  - FSM state enum (IDLE, WAIT, ACCESS, RESP).
  - Byte-enable constants BE_WORD=4'b1111, BE_NONE=4'b0000.
  - Default BASE_ADDR.
- Sub-module rv_mem_array:
  - Single-port synchronous word RAM with 4-bit byte-write enable and registered read.
  - Parameters DEPTH_WORDS and DPWIDTH.
  - No reset on storage.
- rv_dmem_resp holds the FSM, counter, request latches and fault logic.

Test Plan:
- WAIT_STATES=2: store addr=0x1000, be=1111, wdata=0xDEADBEEF accepted at edge N -> ready=1, err=0 in cycle N+4 only; busy high N+1..N+4.
- Load 0x1000 after the above -> rdata=0xDEADBEEF with ready; then store be=0010, wdata=0x0000AA00, then load -> rdata=0xDEADAAEF.
- Load addr=0x1002 (misaligned), and store to 0x0FFC and to 0x1000+4*DEPTH_WORDS -> each gets ready=1, err=1 with normal latency. RAM unchanged: reload 0x1000 gives 0xDEADAAEF. rdata is unchanged on the faulted load.
- WAIT_STATES=0: req held high continuously with two queued loads -> ready pulses exactly 3 cycles apart; second request accepted in the IDLE cycle after the first RESP.
- Store to 0x1004 with wdata=0x12345678; assert rst during WAIT -> no ready, outputs 0, busy=0. After reset, load 0x1004 returns the prior contents, not 0x12345678.
- Store with be=0000 to 0x1008 after writing 0xCAFEF00D there -> ready, err=0; reload gives 0xCAFEF00D.
